// File: rtl/stream_demux_1ton_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1ton_pkg
// Brief    : Shared routing-mode constants and width helper for the 1-to-N
//            stream demultiplexer.
// Revision : 1.0  initial release
// ============================================================================
package stream_demux_1ton_pkg;

    // Routing modes selectable through the MODE parameter
    localparam int c_mode_addr = 0;
    localparam int c_mode_rr   = 1;

    // Ceiling log2, usable in constant expressions for parameter checks
    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_demux_1ton_slot.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1ton_slot
// Brief    : One-entry holding register for a single demux output channel.
//            A load in the same cycle as a drain refills without a bubble.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_1ton_slot
    import stream_demux_1ton_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Load has priority over drain; data only changes on a load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stream_demux_1ton.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1ton
// Brief    : Registered 1-to-N stream demultiplexer with addressed or
//            round-robin routing and independent per-channel stalling.
// Revision : 1.0  initial release
// ============================================================================
module stream_demux_1ton
    import stream_demux_1ton_pkg::*;
#(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SW   = 2,
    parameter int MODE = c_mode_addr
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  in_sel,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic           err,
    output logic [SW-1:0]  rr_ptr
);

    // Channel count in a width that can hold N itself, for the unsigned range test
    localparam logic [SW:0]   c_n    = (SW + 1)'(N);
    localparam logic [SW-1:0] c_last = SW'(N - 1);

    generate
        if (SW < f_clog2(N) || N < 2 || N > 16 || W < 1 ||
            (MODE != c_mode_addr && MODE != c_mode_rr)) begin : g_param_check
            $error("stream_demux_1ton: illegal parameter combination");
        end
    endgenerate

    logic [SW-1:0] r_rr_ptr;
    logic          r_err;
    logic [SW-1:0] w_dest;
    logic          w_legal;
    logic          w_accept;
    logic [N-1:0]  w_hit;
    logic [N-1:0]  w_room;
    logic [N-1:0]  w_valid;

    assign w_dest   = (MODE == c_mode_rr) ? r_rr_ptr : in_sel;
    assign w_legal  = {1'b0, w_dest} < c_n;
    // Illegal beats are always swallowed; legal ones wait for room in their slot
    assign in_ready = ~w_legal | (|(w_hit & w_room));
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar i = 0; i < N; i++) begin : g_slot
            assign w_hit[i]  = w_legal & (w_dest == SW'(i));
            assign w_room[i] = ~w_valid[i] | out_ready[i];

            stream_demux_1ton_slot #(
                .W (W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .load      (w_accept & w_hit[i]),
                .load_data (in_data),
                .out_valid (w_valid[i]),
                .out_ready (out_ready[i]),
                .out_data  (out_data[i*W +: W])
            );
        end
    endgenerate

    // Flag a dropped beat one cycle after it was consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= in_valid & ~w_legal;
        end
    end

    // Round-robin pointer steps only on accepted beats and wraps at N-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if ((MODE == c_mode_rr) && w_accept) begin
            r_rr_ptr <= (r_rr_ptr == c_last) ? '0 : r_rr_ptr + SW'(1);
        end
    end

    assign out_valid = w_valid;
    assign err       = r_err;
    assign rr_ptr    = r_rr_ptr;

endmodule
`default_nettype wire
